cam_stream_gen: RTL and testbench

- Transmit-side counterpart of the camera capture path. Reads RGB332 pixels from the frame-buffer RAM and converts each pixel pair to YUV422 bytes in Y1 U Y2 V order.
- Drives sensor-style vsync/href/cam_data timing so the capture logic can be exercised in loopback without a physical camera.
- Sits between the frame-buffer RAM read port and the camera-bus pins or loopback mux.

---
 rtl/cam_stream_gen_if.sv | 23 ++
 rtl/cam_stream_gen.sv | 169 ++++++++++++++++
 tb/tb_cam_stream_gen.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cam_stream_gen_if.sv
// Frame-buffer read port plus camera-bus pins of the stream generator.
// The master modport is the generator; the slave modport is the RAM/capture side.
interface cam_stream_gen_if #(
  parameter int ADDR_W = 17
);
  logic [ADDR_W-1:0] rdaddress;
  logic              rden;
  logic [7:0]        q;
  logic              vsync;
  logic              href;
  logic [7:0]        cam_data;
  logic              frame_done;

  modport master (
    output rdaddress, rden, vsync, href, cam_data, frame_done,
    input  q
  );

  modport slave (
    input  rdaddress, rden, vsync, href, cam_data, frame_done,
    output q
  );
endinterface

// File: rtl/cam_stream_gen.sv
// RGB332 frame buffer -> YUV422 (Y1 U Y2 V) sensor-style stream with vsync/href timing.
// Outputs registered, one pclk behind the timing counters; free-running, no backpressure.
module cam_stream_gen #(
  parameter int H_ACTIVE    = 320,
  parameter int V_ACTIVE    = 240,
  parameter int H_BLANK     = 32,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 2,
  parameter int V_FRONT     = 2,
  parameter int ADDR_W      = 17
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              enable,
  cam_stream_gen_if.master  bus
);

  localparam int LINE_LEN    = 2 * H_ACTIVE + H_BLANK;
  localparam int ACT_BYTES   = 2 * H_ACTIVE;
  localparam int V_ACT0      = VSYNC_LINES + V_BACK;
  localparam int V_ACT_END   = V_ACT0 + V_ACTIVE;
  localparam int FRAME_LINES = V_ACT_END + V_FRONT;
  localparam int H_W         = $clog2(LINE_LEN);
  localparam int V_W         = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] VSYNC  = 3'd1;
  localparam logic [2:0] VBACK  = 3'd2;
  localparam logic [2:0] ACTIVE = 3'd3;
  localparam logic [2:0] VFRONT = 3'd4;

  logic [2:0]        state;
  logic [H_W-1:0]    h_cnt;
  logic [V_W-1:0]    v_cnt;
  logic [ADDR_W-1:0] rdaddress;
  logic              rden;
  logic              vsync;
  logic              href;
  logic              frame_done;
  logic [7:0]        cam_data;
  logic [7:0]        pix0;

  function automatic logic [2:0] line_state(input int line);
    if (line < VSYNC_LINES)    return VSYNC;
    else if (line < V_ACT0)    return VBACK;
    else if (line < V_ACT_END) return ACTIVE;
    else                       return VFRONT;
  endfunction

  logic line_end;
  logic frame_end;
  logic in_href;
  logic next_line_active;
  logic fetch;
  logic last_href_edge;

  always_comb begin
    line_end         = (int'(h_cnt) == LINE_LEN - 1);
    frame_end        = line_end && (int'(v_cnt) == FRAME_LINES - 1);
    in_href          = (state == ACTIVE) && (int'(h_cnt) < ACT_BYTES);
    next_line_active = (line_state(int'(v_cnt) + 1) == ACTIVE);
    // Pixel c of a line is read so q holds it at byte slot 2c; pixel 0 is
    // requested in the last blank cycle of the preceding line.
    fetch = (in_href && !h_cnt[0] && (int'(h_cnt) < ACT_BYTES - 2)) ||
            ((state != IDLE) && next_line_active && (int'(h_cnt) == LINE_LEN - 2));
    last_href_edge = (state == ACTIVE) && (int'(v_cnt) == V_ACT_END - 1) &&
                     (int'(h_cnt) == ACT_BYTES);
  end

  logic [7:0]        src;
  logic [7:0]        r8;
  logic [7:0]        g8;
  logic [7:0]        b8;
  logic [17:0]       acc;
  logic [17:0]       y_sh;
  logic [7:0]        y8;
  logic signed [9:0] du;
  logic signed [9:0] dv;
  logic signed [9:0] u10;
  logic signed [9:0] v10;
  logic [7:0]        u8;
  logic [7:0]        v8;
  logic [7:0]        byte_nxt;

  // Y1 and Y2 slots convert the pixel arriving on q; U and V slots reuse the
  // latched even pixel.
  always_comb begin
    src  = h_cnt[0] ? pix0 : bus.q;
    r8   = {src[7:5], src[7:5], src[7:6]};
    g8   = {src[4:2], src[4:2], src[4:3]};
    b8   = {4{src[1:0]}};
    acc  = 18'd77  * {10'd0, r8} +
           18'd150 * {10'd0, g8} +
           18'd29  * {10'd0, b8};
    y_sh = acc >> 8;
    y8   = (y_sh > 18'd255) ? 8'hFF : y_sh[7:0];
    du   = $signed({2'b00, b8}) - $signed({2'b00, y8});
    dv   = $signed({2'b00, r8}) - $signed({2'b00, y8});
    u10  = 10'sd128 + (du >>> 1);
    v10  = 10'sd128 + (dv >>> 1);
    u8   = (u10 < 10'sd0) ? 8'd0 : ((u10 > 10'sd255) ? 8'hFF : u10[7:0]);
    v8   = (v10 < 10'sd0) ? 8'd0 : ((v10 > 10'sd255) ? 8'hFF : v10[7:0]);
    case (h_cnt[1:0])
      2'd1:    byte_nxt = u8;
      2'd3:    byte_nxt = v8;
      default: byte_nxt = y8;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state      <= IDLE;
      h_cnt      <= '0;
      v_cnt      <= '0;
      rdaddress  <= '0;
      rden       <= 1'b0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      frame_done <= 1'b0;
      cam_data   <= 8'd0;
      pix0       <= 8'd0;
    end else begin
      vsync      <= (state == VSYNC);
      href       <= in_href;
      cam_data   <= in_href ? byte_nxt : 8'd0;
      frame_done <= last_href_edge;
      rden       <= fetch;

      if (in_href && (h_cnt[1:0] == 2'd0)) begin
        pix0 <= bus.q;
      end

      if (state == IDLE) begin
        h_cnt <= '0;
        v_cnt <= '0;
        if (enable) begin
          state     <= VSYNC;
          rdaddress <= '0;
        end
      end else begin
        if (rden) begin
          rdaddress <= rdaddress + 1'b1;
        end
        if (line_end) begin
          h_cnt <= '0;
          if (frame_end) begin
            // Enable is only honoured at frame boundaries.
            v_cnt     <= '0;
            rdaddress <= '0;
            state     <= enable ? VSYNC : IDLE;
          end else begin
            v_cnt <= v_cnt + 1'b1;
            state <= line_state(int'(v_cnt) + 1);
          end
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.rdaddress  = rdaddress;
  assign bus.rden       = rden;
  assign bus.vsync      = vsync;
  assign bus.href       = href;
  assign bus.cam_data   = cam_data;
  assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_cam_stream_gen.sv
// Scoreboard bench for cam_stream_gen on a 4x2 frame with 4-cycle blanking.
module tb_cam_stream_gen;
  localparam int H_ACTIVE    = 4;
  localparam int V_ACTIVE    = 2;
  localparam int H_BLANK     = 4;
  localparam int VSYNC_LINES = 1;
  localparam int V_BACK      = 1;
  localparam int V_FRONT     = 1;
  localparam int ADDR_W      = 17;

  logic pclk = 1'b0;
  logic reset;
  logic enable;

  cam_stream_gen_if #(.ADDR_W(ADDR_W)) bus ();

  cam_stream_gen #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
    .VSYNC_LINES(VSYNC_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT),
    .ADDR_W(ADDR_W)
  ) dut (
    .pclk(pclk), .reset(reset), .enable(enable), .bus(bus)
  );

  always #5 pclk = ~pclk;

  logic [7:0] mem [0:7];
  always @(posedge pclk) if (bus.rden) bus.q <= mem[bus.rdaddress[2:0]];

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q [$];
  logic [7:0] pix_mixed [0:7];
  logic [7:0] exp_mixed [0:15];
  logic expect_period = 1'b0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor state
  logic m_prev_vsync, m_prev_href, m_prev_done, m_in_frame;
  int m_cyc, m_last_rise, m_vlen, m_hlen, m_rd_cnt, m_lines, m_dones, m_pf_wait;

  initial begin
    m_cyc = 0;
    forever begin
      @(negedge pclk);
      m_cyc++;
      if (reset) begin
        m_prev_vsync = 0; m_prev_href = 0; m_prev_done = 0; m_in_frame = 0;
        m_last_rise = -1; m_vlen = 0; m_hlen = 0; m_rd_cnt = 0; m_lines = 0;
        m_dones = 0; m_pf_wait = 0;
      end else begin
        if (bus.href) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_byte: got %0h, want no byte", bus.cam_data);
          end else begin
            check("cam_data", bus.cam_data, exp_q.pop_front());
          end
          m_hlen++;
        end else begin
          check("cam_data_blank", bus.cam_data, 0);
        end
        if (!bus.href && m_prev_href) begin
          check("href_len", m_hlen, 2 * H_ACTIVE);
          m_lines++;
          m_hlen = 0;
        end
        if (bus.vsync && !m_prev_vsync) begin
          if (m_in_frame) check("dones_per_frame", m_dones, 1);
          if (expect_period && m_last_rise >= 0) check("frame_period", m_cyc - m_last_rise, 60);
          m_last_rise = m_cyc; m_in_frame = 1; m_rd_cnt = 0; m_lines = 0;
          m_dones = 0; m_vlen = 0;
        end
        if (bus.vsync) m_vlen++;
        if (!bus.vsync && m_prev_vsync) check("vsync_len", m_vlen, 12);
        if (m_pf_wait > 0) begin
          m_pf_wait--;
          if (m_pf_wait == 0) check("prefetch_follow", bus.href, 1);
        end
        if (bus.rden) begin
          check("rdaddress", bus.rdaddress, m_rd_cnt);
          m_rd_cnt++;
          if (!bus.href) m_pf_wait = 2;
        end
        if (bus.frame_done) begin
          check("done_align", {m_prev_href, bus.href}, 2'b10);
          check("done_width", m_prev_done, 0);
          check("done_reads", m_rd_cnt, 8);
          check("done_lines", m_lines, 2);
          m_dones++;
          done_cnt++;
        end
        m_prev_vsync = bus.vsync;
        m_prev_href  = bus.href;
        m_prev_done  = bus.frame_done;
      end
    end
  end

  task automatic setup_frame(input int mode);
    for (int i = 0; i < 8; i++)
      mem[i] = (mode == 0) ? pix_mixed[i] : ((mode == 1) ? 8'hFF : 8'h00);
    for (int i = 0; i < 16; i++) begin
      if (mode == 0)      exp_q.push_back(exp_mixed[i]);
      else if (i % 2)     exp_q.push_back(8'h80);
      else if (mode == 1) exp_q.push_back(8'hFF);
      else                exp_q.push_back(8'h00);
    end
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done_cnt < target && n < 400) begin
      @(negedge pclk);
      n++;
    end
    check(name, done_cnt, target);
  endtask

  task automatic wait_href_rise(input string name);
    int n = 0;
    while (bus.href !== 1'b1 && n < 200) begin
      @(negedge pclk);
      n++;
    end
    check(name, bus.href, 1);
  endtask

  task automatic check_idle(input string name);
    int act = 0;
    repeat (20) @(negedge pclk);
    repeat (30) begin
      @(negedge pclk);
      if (bus.vsync || bus.href || bus.rden || bus.frame_done || bus.cam_data != 0) act++;
    end
    check(name, act, 0);
    check({name, "_rdaddress"}, bus.rdaddress, 0);
    check({name, "_queue"}, exp_q.size(), 0);
  endtask

  initial begin
    int target;
    int n;
    reset  = 1'b1;
    enable = 1'b0;
    pix_mixed = '{8'hE0, 8'h03, 8'h03, 8'hE0, 8'hFF, 8'hFF, 8'h00, 8'h00};
    exp_mixed = '{8'h4C, 8'h5A, 8'h1C, 8'hD9, 8'h1C, 8'hF1, 8'h4C, 8'h72,
                  8'hFF, 8'h80, 8'hFF, 8'h80, 8'h00, 8'h80, 8'h00, 8'h80};
    repeat (3) @(posedge pclk);
    #1;
    check("rst_vsync", bus.vsync, 0);
    check("rst_href", bus.href, 0);
    check("rst_cam_data", bus.cam_data, 0);
    check("rst_rden", bus.rden, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_rdaddress", bus.rdaddress, 0);
    @(negedge pclk); #2 reset = 1'b0;

    // Two back-to-back frames, enable dropped during the second.
    expect_period = 1'b1;
    setup_frame(0);
    setup_frame(0);
    enable = 1'b1;
    wait_done(1, "frame1_done");
    wait_href_rise("frame2_href");
    expect_period = 1'b0;
    enable = 1'b0;
    wait_done(2, "frame2_done");
    check_idle("idle_after_f2");

    // Uniform frames, each restarted from IDLE.
    for (int m = 1; m <= 2; m++) begin
      target = done_cnt + 1;
      setup_frame(m);
      enable = 1'b1;
      wait_href_rise("uniform_href");
      enable = 1'b0;
      wait_done(target, "uniform_done");
      check_idle("idle_after_uniform");
    end

    // Reset on the third active byte of the first line.
    setup_frame(0);
    enable = 1'b1;
    wait_href_rise("rst_test_href");
    repeat (2) @(negedge pclk);
    check("third_byte", bus.cam_data, 8'h1C);
    #2 reset = 1'b1;
    @(posedge pclk); #1;
    check("midrst_href", bus.href, 0);
    check("midrst_cam_data", bus.cam_data, 0);
    check("midrst_vsync", bus.vsync, 0);
    check("midrst_rden", bus.rden, 0);
    exp_q.delete();
    repeat (2) @(negedge pclk);
    #2 reset = 1'b0;
    target = done_cnt + 1;
    setup_frame(0);
    n = 0;
    while (bus.vsync !== 1'b1 && n < 4) begin
      @(negedge pclk);
      n++;
    end
    check("vsync_restart", bus.vsync, 1);
    wait_href_rise("restart_href");
    enable = 1'b0;
    wait_done(target, "restart_done");
    check_idle("idle_after_restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
